// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial load/store initiator for an 8-bit req/ack data-memory port
// Splits one load/store into little-endian byte strobes, extends loads, flags misalignment/timeouts.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 16,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqUnsigned,
    input  logic [ADDR_WIDTH-1:0] reqAddress,
    input  logic [31:0]           reqWriteData,
    output logic                  busy,
    output logic                  respValid,
    output logic [31:0]           respData,
    output logic                  error,
    output logic [1:0]            errorCause,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [7:0]            memWriteData,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic                  memAck,
    input  logic [7:0]            memReadData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_SIZE     = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           tmo_q, tmo_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic                  err_q, err_d;
    logic [1:0]            cause_q, cause_d;

    logic                  in_access;
    logic [1:0]            last_idx;
    logic [31:0]           load_ext;

    assign in_access = (state_q == S_ACCESS);
    // Index of the final byte: 0, 1 or 3 for byte, half, word.
    assign last_idx  = (size_q == 2'b10) ? 2'd3 : {1'b0, size_q[0]};

    assign reqReady     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign respValid    = (state_q == S_DONE);
    assign respData     = resp_data_q;
    assign error        = err_q;
    assign errorCause   = cause_q;
    assign memRead      = in_access && !write_q;
    assign memWrite     = in_access && write_q;
    assign memAddress   = in_access ? (addr_q + {{(ADDR_WIDTH-2){1'b0}}, idx_q}) : '0;
    assign memWriteData = in_access ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;

    always_comb begin
        load_ext = rdata_d;
        case (size_q)
            2'b00:   load_ext = {{24{!unsigned_q && rdata_d[7]}}, rdata_d[7:0]};
            2'b01:   load_ext = {{16{!unsigned_q && rdata_d[15]}}, rdata_d[15:0]};
            default: load_ext = rdata_d;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        cause_d     = cause_q;

        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    write_d    = reqWrite;
                    size_d     = reqSize;
                    unsigned_d = reqUnsigned;
                    addr_d     = reqAddress;
                    wdata_d    = reqWriteData;
                    idx_d      = 2'd0;
                    tmo_d      = 32'd0;
                    rdata_d    = 32'd0;
                    if (reqSize == 2'b11) begin
                        state_d     = S_DONE;
                        err_d       = 1'b1;
                        cause_d     = CAUSE_SIZE;
                        resp_data_d = 32'd0;
                    end else if ((reqSize == 2'b01 && reqAddress[0]) ||
                                 (reqSize == 2'b10 && reqAddress[1:0] != 2'b00)) begin
                        state_d     = S_DONE;
                        err_d       = 1'b1;
                        cause_d     = CAUSE_MISALIGN;
                        resp_data_d = 32'd0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (memAck) begin
                    rdata_d[{idx_q, 3'b000} +: 8] = memReadData;
                    idx_d = idx_q + 2'd1;
                    tmo_d = 32'd0;
                    if (idx_q == last_idx) begin
                        state_d     = S_DONE;
                        err_d       = 1'b0;
                        cause_d     = CAUSE_NONE;
                        resp_data_d = write_q ? 32'd0 : load_ext;
                    end
                end else if (ACK_TIMEOUT > 0) begin
                    if (tmo_q == 32'(ACK_TIMEOUT - 1)) begin
                        state_d     = S_DONE;
                        err_d       = 1'b1;
                        cause_d     = CAUSE_TIMEOUT;
                        resp_data_d = 32'd0;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            idx_q       <= 2'd0;
            tmo_q       <= 32'd0;
            rdata_q     <= 32'd0;
            resp_data_q <= 32'd0;
            err_q       <= 1'b0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            rdata_q     <= rdata_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqValid, reqReady, reqWrite, reqUnsigned;
    logic [1:0]    reqSize;
    logic [AW-1:0] reqAddress;
    logic [31:0]   reqWriteData;
    logic          busy, respValid, error;
    logic [31:0]   respData;
    logic [1:0]    errorCause;
    logic [AW-1:0] memAddress;
    logic [7:0]    memWriteData, memReadData;
    logic          memWrite, memRead, memAck;

    always #5 clk = ~clk;

    load_store_unit #(.ACK_TIMEOUT(4), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddress(reqAddress),
        .reqWriteData(reqWriteData), .busy(busy), .respValid(respValid),
        .respData(respData), .error(error), .errorCause(errorCause),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memWrite(memWrite), .memRead(memRead), .memAck(memAck),
        .memReadData(memReadData)
    );

    // Memory model: 16 bytes, ack after wait_n stall cycles per byte.
    logic [7:0] mem [0:15];
    int         cyc = 0;
    int         wait_n = 0;
    bit         ack_en = 1'b1;
    int         wcnt = 0;
    int         strobe_cycles = 0;
    int         unstable = 0;
    bit         holding = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [7:0] hold_wd;
    int         wr_addr[$];
    int         wr_data[$];
    int         wr_cyc[$];

    assign memAck      = (memRead || memWrite) && ack_en && (wcnt == wait_n);
    assign memReadData = mem[memAddress[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memRead || memWrite) strobe_cycles++;
        if (holding && (!(memRead || memWrite) || memAddress != hold_addr || memWriteData != hold_wd))
            unstable++;
        holding   = (memRead || memWrite) && !memAck && !reset;
        hold_addr = memAddress;
        hold_wd   = memWriteData;
        if (reset || !(memRead || memWrite) || memAck) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (memWrite && memAck) begin
            mem[memAddress[3:0]] <= memWriteData;
            wr_addr.push_back(int'(memAddress));
            wr_data.push_back(int'(memWriteData));
            wr_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issues one request and waits (bounded) for its completion pulse.
    task automatic do_req(input bit w, input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int t0, output int lat, output logic [31:0] rd,
                          output logic er, output logic [1:0] ca);
        @(negedge clk);
        check("ready_before_req", {31'd0, reqReady}, 32'd1);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = u;
        reqAddress = a; reqWriteData = d;
        t0  = cyc;
        lat = -1;
        @(negedge clk);
        reqValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (respValid) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        rd = respData; er = error; ca = errorCause;
        if (lat < 0) check("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("resp_one_cycle", {31'd0, respValid}, 32'd0);
        check("resp_hold", respData, rd);
    endtask

    int          t0, lat;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  ca;
    int          rv_seen;

    initial begin
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqUnsigned = 1'b0; reqAddress = '0; reqWriteData = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, reqReady}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_resp", {31'd0, respValid}, 32'd0);
        check("rst_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("rst_data", respData, 32'd0);
        check("rst_cause", {30'd0, errorCause}, 32'd0);
        check("rst_addr", memAddress, 32'd0);
        reset = 1'b0;

        // Word store, zero-wait memory.
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hF000F002, t0, lat, rd, er, ca);
        check("st_w_lat", lat, 32'd5);
        check("st_w_err", {31'd0, er}, 32'd0);
        check("st_w_data", rd, 32'd0);
        check("st_w_nwr", wr_addr.size(), 32'd4);
        if (wr_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("st_w_addr", wr_addr[i], 32'(4 + i));
                check("st_w_cyc", wr_cyc[i] - t0, 32'(1 + i));
            end
            check("st_w_b0", wr_data[0], 32'h02);
            check("st_w_b1", wr_data[1], 32'hF0);
            check("st_w_b2", wr_data[2], 32'h00);
            check("st_w_b3", wr_data[3], 32'hF0);
        end

        // Byte loads of 0xF0 at 0x5, signed then unsigned.
        do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, t0, lat, rd, er, ca);
        check("ld_b_s_lat", lat, 32'd2);
        check("ld_b_s_data", rd, 32'hFFFFFFF0);
        do_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, t0, lat, rd, er, ca);
        check("ld_b_u_data", rd, 32'h000000F0);
        check("ld_b_u_err", {31'd0, er}, 32'd0);

        // Half load at 0x6 (bytes 00, F0) with two wait cycles per byte.
        wait_n = 2; unstable = 0;
        do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, t0, lat, rd, er, ca);
        check("ld_h_lat", lat, 32'd7);
        check("ld_h_data", rd, 32'hFFFFF000);
        check("ld_h_stable", unstable, 32'd0);
        wait_n = 0;

        // Word load, signed value unchanged.
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, t0, lat, rd, er, ca);
        check("ld_w_lat", lat, 32'd5);
        check("ld_w_data", rd, 32'hF000F002);

        // Error paths: no strobe, one-cycle latency.
        strobe_cycles = 0;
        do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, t0, lat, rd, er, ca);
        check("mis_w_lat", lat, 32'd1);
        check("mis_w_err", {30'd0, er, 1'b0} | {30'd0, ca}, 32'd3);
        do_req(1'b1, 2'b01, 1'b0, 32'h1, 32'h0, t0, lat, rd, er, ca);
        check("mis_h_cause", {29'd0, er, ca}, 32'h5);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, t0, lat, rd, er, ca);
        check("size_cause", {29'd0, er, ca}, 32'h6);
        check("size_data", rd, 32'd0);
        check("err_no_strobe", strobe_cycles, 32'd0);

        // Timeout: memory never acks.
        ack_en = 1'b0; strobe_cycles = 0;
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, t0, lat, rd, er, ca);
        check("tmo_strobes", strobe_cycles, 32'd4);
        check("tmo_lat", lat, 32'd5);
        check("tmo_cause", {29'd0, er, ca}, 32'h7);
        check("tmo_data", rd, 32'd0);
        ack_en = 1'b1;
        do_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, t0, lat, rd, er, ca);
        check("post_tmo_data", rd, 32'h000000F0);
        check("post_tmo_err", {31'd0, er}, 32'd0);

        // Reset while the second byte of a word store is on the bus.
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqAddress = 32'h8;
        reqWriteData = 32'h11223344;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        check("rst_mid_addr", memAddress, 32'h9);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_strobe", {30'd0, memRead, memWrite}, 32'd0);
        check("rst_mid_ready", {31'd0, reqReady}, 32'd1);
        check("rst_mid_resp", {31'd0, respValid}, 32'd0);
        reset = 1'b0;
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (respValid) rv_seen++;
        end
        check("rst_mid_noresp", rv_seen, 32'd0);
        check("rst_mid_partial", {24'd0, mem[8]}, 32'h44);
        do_req(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, t0, lat, rd, er, ca);
        check("rst_mid_reload", rd, 32'h00000044);
        check("rst_mid_lat", lat, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
